pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC, target and EPC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_3000: PC value loaded by reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180: PC value loaded on exception entry.
REQ-004 Parameter STEP, default 4: sequential increment.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset of all state.
REQ-007 stall  in  1  holds sequential advance and delays branch redirects.
REQ-008 br_valid  in  1  branch/jump redirect request.
REQ-009 br_target  in  WIDTH  redirect destination.
REQ-010 exc_req  in  1  exception/interrupt entry request.
REQ-011 exc_epc  in  WIDTH  return address to save on exception entry.
REQ-012 eret  in  1  exception return request.
REQ-013 pc  out  WIDTH  current fetch address (registered).
REQ-014 pc_seq  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH.
REQ-015 epc  out  WIDTH  saved exception return address (registered).
REQ-016 exl  out  1  exception level; 1 while inside handler.
REQ-017 redir_pending  out  1  1 while a stalled branch redirect is held.
REQ-018 misalign  out  1  combinational; 1 when pc mod STEP != 0.

Function
REQ-019 State machine: RUN (no held redirect), HOLD (redirect held in pend_target); redir_pending = (state == HOLD).
REQ-020 Per-edge priority, highest first: exc_req, eret (only if exl=1), redirect, sequential, hold.
REQ-021 exc_req=1: pc <= EXC_VEC regardless of stall; exl <= 1; state -> RUN (held redirect discarded).
REQ-022 exc_req=1 with exl=0: epc <= exc_epc; with exl=1 (nested): epc unchanged.
REQ-023 eret=1, exc_req=0, exl=1: pc <= epc regardless of stall; exl <= 0; state -> RUN.
REQ-024 eret=1 with exl=0: ignored; behaviour identical to eret=0.
REQ-025 br_valid=1, stall=0, no higher event: pc <= br_target; state -> RUN.
REQ-026 br_valid=1, stall=1, no higher event: pend_target <= br_target; state -> HOLD; pc unchanged.
REQ-027 HOLD, stall=1, br_valid=1: pend_target overwritten by newest br_target (newest wins).
REQ-028 HOLD, stall=0, br_valid=0, no higher event: pc <= pend_target; state -> RUN.
REQ-029 HOLD, stall=0, br_valid=1: pc <= br_target (live request wins over held); state -> RUN.
REQ-030 RUN, stall=0, no request: pc <= pc + STEP, wrapping modulo 2^WIDTH (no carry out).
REQ-031 RUN, stall=1, no request: pc, state unchanged.
REQ-032 Redirect latency: one edge from request to pc update; held redirect applied on first edge with stall=0.
REQ-033 misalign is reported only; pc is never auto-corrected or trapped internally.

Reset
REQ-034 reset=1 asynchronously forces pc=RESET_VEC, epc=0, exl=0, state=RUN, pend_target=0, without waiting for clk.
REQ-035 reset dominates all inputs while asserted; first edge after deassertion follows REQ-020.
REQ-036 Reset during HOLD discards the held redirect; no redirect is applied after release.

Verification
REQ-037 Reset pulse mid-cycle, then 3 edges with no requests -> pc 3000 immediately, then 3004, 3008, 300C.
REQ-038 pc=3010, stall=1, br_valid with 3100 then 3200 on consecutive edges, stall drops -> pc holds 3010, redir_pending=1, then pc=3200, redir_pending=0.
REQ-039 pc=3020, stall=1, exc_req with exc_epc=3020 -> pc=4180, epc=3020, exl=1; eret next edge -> pc=3020, exl=0.
REQ-040 exl=1, epc=3020, second exc_req with exc_epc=4190 -> pc=4180, epc stays 3020; eret with exl=0 afterwards -> ignored, pc advances by STEP.
REQ-041 WIDTH=32, pc=FFFF_FFFC, no request -> pc=0000_0000; br_target=3002 -> misalign=1 on following cycle.
REQ-042 Same edge exc_req, eret, br_valid all high -> pc=4180, exl=1, redir_pending=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with sequential advance, stall-deferred branch redirects,
// and single-level exception entry/return bookkeeping (epc, exl).
module pc_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h0000_4180,
    parameter int                 STEP      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_epc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic [WIDTH-1:0] epc,
    output logic             exl,
    output logic             redir_pending,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic {RUN, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic             exl_reg, exl_next;
    logic [WIDTH-1:0] pend_target_reg, pend_target_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg          <= RESET_VEC;
            epc_reg         <= '0;
            exl_reg         <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            epc_reg         <= epc_next;
            exl_reg         <= exl_next;
            pend_target_reg <= pend_target_next;
        end
    end

    // Priority: exception, return (only inside handler), live redirect,
    // held redirect, sequential advance, hold.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        epc_next         = epc_reg;
        exl_next         = exl_reg;
        pend_target_next = pend_target_reg;

        if (exc_req) begin
            pc_next    = EXC_VEC;
            exl_next   = 1'b1;
            state_next = RUN;
            if (!exl_reg) begin
                epc_next = exc_epc;
            end
        end else if (eret && exl_reg) begin
            pc_next    = epc_reg;
            exl_next   = 1'b0;
            state_next = RUN;
        end else if (br_valid) begin
            if (stall) begin
                pend_target_next = br_target;
                state_next       = HOLD;
            end else begin
                pc_next    = br_target;
                state_next = RUN;
            end
        end else begin
            case (state_reg)
                HOLD: begin
                    if (!stall) begin
                        pc_next    = pend_target_reg;
                        state_next = RUN;
                    end
                end
                default: begin
                    if (!stall) begin
                        pc_next = pc_reg + STEP_W;
                    end
                end
            endcase
        end
    end

    always_comb begin
        redir_pending = (state_reg == HOLD);
        pc_seq        = pc_reg + STEP_W;
        misalign      = ((pc_reg % STEP_W) != '0);
    end

    assign pc  = pc_reg;
    assign epc = epc_reg;
    assign exl = exl_reg;

endmodule
